// File: rtl/clkgen_pkg.sv
// Shared types, defaults and helpers for the lock-supervised clock-enable generator.
package clkgen_pkg;

  localparam int unsigned DIVW_DEF        = 16;
  localparam int unsigned LOCK_CYCLES_DEF = 1024;
  localparam int unsigned RST_CYCLES_DEF  = 16;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_QUALIFY   = 2'd1,
    ST_RST_HOLD  = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkgen_multi_ce_divider.sv
// One clock-enable channel: wrap counter, active divider and a shadow that lands on a period boundary.
module ce_divider
  import clkgen_pkg::*;
#(
  parameter int unsigned DIVW     = DIVW_DEF,
  parameter int unsigned DIV_INIT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            resync,
  input  logic            we,
  input  logic [DIVW-1:0] wdata,
  output logic            ce
);

  logic [DIVW-1:0] ctr_q;
  logic [DIVW-1:0] div_q;
  logic [DIVW-1:0] sh_q;
  logic            pend_q;
  logic            wrap;

  assign wrap = (ctr_q == div_q);
  assign ce   = run & wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q  <= '0;
      div_q  <= DIVW'(DIV_INIT);
      sh_q   <= '0;
      pend_q <= 1'b0;
    end else if (!run) begin
      // Counters are parked, so any divider change can take effect at once.
      ctr_q  <= '0;
      pend_q <= 1'b0;
      if (we)          div_q <= wdata;
      else if (pend_q) div_q <= sh_q;
    end else begin
      if (resync || wrap) begin
        ctr_q <= '0;
        if (pend_q) begin
          div_q  <= sh_q;
          pend_q <= 1'b0;
        end
      end else begin
        ctr_q <= ctr_q + DIVW'(1);
      end
      // A write coinciding with a wrap or resync becomes the next pending value.
      if (we) begin
        sh_q   <= wdata;
        pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clkgen_multi.sv
// Lock qualification, downstream reset sequencing and NCH programmable clock-enable channels.
module clkgen_multi
  import clkgen_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned DIVW        = DIVW_DEF,
  parameter int unsigned DIV_INIT    = 0,
  parameter int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int unsigned RST_CYCLES  = RST_CYCLES_DEF
) (
  input  logic                     clock_in,
  input  logic                     resetn,
  input  logic                     locked,
  input  logic                     cfg_we,
  input  logic [ch_width(NCH)-1:0] cfg_ch,
  input  logic [DIVW-1:0]          cfg_div,
  input  logic                     resync,
  output logic [NCH-1:0]           ce,
  output logic                     rst_out_n,
  output logic                     ready
);

  localparam int unsigned CHW     = ch_width(NCH);
  localparam int unsigned CNT_MAX = (LOCK_CYCLES > RST_CYCLES) ? LOCK_CYCLES : RST_CYCLES;
  localparam int unsigned CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [1:0]      sync_q;
  logic            lock_s;
  state_t          state_q, state_nxt;
  logic [CNTW-1:0] cnt_q, cnt_nxt;
  logic            run_q;

  // locked is asynchronous to clock_in; only lock_s is used past this point.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[0], locked};
  end

  assign lock_s = sync_q[1];

  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_WAIT_LOCK;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      run_q   <= (state_nxt == ST_RUN);
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      ST_WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) state_nxt = ST_QUALIFY;
      end
      ST_QUALIFY: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt_q == CNTW'(LOCK_CYCLES - 1)) begin
          state_nxt = ST_RST_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNTW'(1);
        end
      end
      ST_RST_HOLD: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt_q == CNTW'(RST_CYCLES - 1)) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNTW'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) state_nxt = ST_WAIT_LOCK;
      end
      default: begin
        state_nxt = ST_WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign ready     = run_q;
  assign rst_out_n = run_q;

  // Out-of-range channel selects match no channel and are dropped.
  for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
    logic ch_we;
    assign ch_we = cfg_we && (cfg_ch == CHW'(i));

    ce_divider #(
      .DIVW     (DIVW),
      .DIV_INIT (DIV_INIT)
    ) u_div (
      .clk    (clock_in),
      .rst_n  (resetn),
      .run    (run_q),
      .resync (resync),
      .we     (ch_we),
      .wdata  (cfg_div),
      .ce     (ce[i])
    );
  end

endmodule

// File: tb/tb_clkgen_multi.sv
// Scoreboard bench for clkgen_multi: a cycle-schedule reference model predicts ready/ce, a monitor compares.
module tb_clkgen_multi;

  localparam int unsigned NCH  = 5;
  localparam int unsigned DIVW = 8;
  localparam int unsigned LCK  = 8;
  localparam int unsigned RST  = 4;
  localparam int unsigned CHW  = 3;
  localparam int          LATENCY = 2 + LCK + RST;

  typedef struct packed {
    logic           rdy;
    logic [NCH-1:0] ce;
  } exp_t;

  logic            clk = 1'b0;
  logic            resetn, locked, cfg_we, resync;
  logic [CHW-1:0]  cfg_ch;
  logic [DIVW-1:0] cfg_div;
  logic [NCH-1:0]  ce;
  logic            rst_out_n, ready;

  int vectors = 0;
  int miscompares = 0;

  clkgen_multi #(
    .NCH         (NCH),
    .DIVW        (DIVW),
    .DIV_INIT    (0),
    .LOCK_CYCLES (LCK),
    .RST_CYCLES  (RST)
  ) dut (
    .clock_in  (clk),
    .resetn    (resetn),
    .locked    (locked),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .resync    (resync),
    .ce        (ce),
    .rst_out_n (rst_out_n),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  // Reference model: ready needs LCK+RST+1 consecutive high lock samples ending two edges back;
  // each channel is scheduled by the absolute cycle number of its next strobe.
  exp_t exp_q[$];
  int   cyc = 0;
  int   streak, sd1, sd2, rise_edge;
  bit   prev_run, started;
  int   m_div [NCH];
  int   m_sh  [NCH];
  bit   m_pend[NCH];
  int   next_hi[NCH];

  always @(posedge clk) begin
    exp_t e;
    bit   rdy, we_i;
    cyc++;
    e = '0;
    if (!resetn) begin
      streak = 0; sd1 = 0; sd2 = 0; prev_run = 0;
      for (int i = 0; i < int'(NCH); i++) begin
        m_div[i] = 0; m_sh[i] = 0; m_pend[i] = 0; next_hi[i] = 0;
      end
    end else begin
      rdy = (sd2 >= int'(LCK + RST + 1));
      sd2 = sd1;
      streak = locked ? streak + 1 : 0;
      sd1 = streak;
      if (streak == 1) rise_edge = cyc;
      for (int i = 0; i < int'(NCH); i++) begin
        we_i = cfg_we && (int'(cfg_ch) == i);
        if (!prev_run) begin
          if (m_pend[i]) m_div[i] = m_sh[i];
          m_pend[i] = 0;
          if (we_i) m_div[i] = int'(cfg_div);
          next_hi[i] = cyc + m_div[i];
        end else begin
          if (resync || (next_hi[i] == cyc - 1)) begin
            if (m_pend[i]) begin
              m_div[i] = m_sh[i];
              m_pend[i] = 0;
            end
            next_hi[i] = cyc + m_div[i];
          end
          if (we_i) begin
            m_sh[i] = int'(cfg_div);
            m_pend[i] = 1;
          end
        end
        e.ce[i] = rdy && (next_hi[i] == cyc);
      end
      e.rdy = rdy;
      prev_run = rdy;
    end
    exp_q.push_back(e);
    started = 1;
  end

  // Monitor: pops one prediction per cycle and also checks lock-to-ready latency on every rise.
  logic prev_rdy_dut = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL cyc=%0d scoreboard: no prediction queued", cyc);
      end else begin
        e = exp_q.pop_front();
        if (!resetn) e = '0;
        if (ce !== e.ce || ready !== e.rdy || rst_out_n !== e.rdy) begin
          miscompares++;
          $display("FAIL cyc=%0d outputs: ce got %b exp %b, ready got %b exp %b, rst_out_n got %b exp %b",
                   cyc, ce, e.ce, ready, e.rdy, rst_out_n, e.rdy);
        end
      end
      if (rst_out_n === 1'b1 && prev_rdy_dut === 1'b0) begin
        vectors++;
        if (cyc - rise_edge != LATENCY) begin
          miscompares++;
          $display("FAIL cyc=%0d lock_latency: got %0d edges exp %0d", cyc, cyc - rise_edge, LATENCY);
        end
      end
      prev_rdy_dut = rst_out_n;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int ch, input int d);
    cfg_we  = 1'b1;
    cfg_ch  = CHW'(ch);
    cfg_div = DIVW'(d);
    step();
    cfg_we  = 1'b0;
  endtask

  task automatic random_phase(input int n);
    for (int k = 0; k < n; k++) begin
      cfg_we  = ($urandom_range(3) == 0);
      cfg_ch  = CHW'($urandom_range(7));
      cfg_div = DIVW'($urandom_range(12));
      resync  = ($urandom_range(19) == 0);
      locked  = ($urandom_range(149) != 0);
      step();
    end
    cfg_we = 1'b0;
    resync = 1'b0;
    locked = 1'b1;
  endtask

  initial begin
    int n;
    resetn = 1'b0; locked = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; resync = 1'b0;
    step(3);
    resetn = 1'b1;
    wr(0, 0); wr(1, 1); wr(2, 3); wr(3, 9); wr(4, 4);
    step(3);
    // Lock with a one-cycle dropout during qualification.
    locked = 1'b1; step(5);
    locked = 1'b0; step(1);
    locked = 1'b1; step(40);
    // Mid-period write then overwrite on ch2, plus out-of-range selects.
    wr(2, 7); step(1); wr(2, 5);
    wr(5, 1); wr(6, 2); wr(7, 3);
    step(30);
    // Resync on the ch1 wrap cycle while a ch1 write is pending.
    n = 0;
    while (ce[1] !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL cyc=%0d resync_setup: ce[1] got %b exp 0 within 50 cycles", cyc, ce[1]);
    end
    wr(1, 4);
    resync = 1'b1; step(); resync = 1'b0;
    step(20);
    random_phase(300);
    step(20);
    // Lock loss and re-lock.
    locked = 1'b0; step(6);
    locked = 1'b1; step(30);
    // Asynchronous reset mid-operation.
    resetn = 1'b0; step(2);
    resetn = 1'b1;
    wr(0, 2); wr(3, 1);
    step(25);
    random_phase(200);
    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
